// File: rtl/xex_block_sequencer.sv
// Sector job sequencer: feeds host blocks one at a time into the XEX engine and returns results in order.
// Latency: start at edge N -> busy/mode from N+1, first in_rdy at N+2; engine result visible one cycle after out_rdy.
// Backpressure: wr_ready drops on full 2-entry FIFO or job quota reached; no new block issues while rd_valid is held.
// Optional build macro XEX_SEQ_WATCHDOG_EN adds a WAIT-state watchdog that aborts a stuck job with job_err.
module xex_block_sequencer #(
  parameter int MAX_BLOCKS = 32,
  parameter int WD_LIMIT   = 255
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         cmd_start,
  input  logic         cmd_dec,
  input  logic [127:0] cmd_sector,
  input  logic [5:0]   cmd_nblocks,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [127:0] wr_data,
  output logic         rd_valid,
  input  logic         rd_ready,
  output logic [127:0] rd_data,
  output logic         job_busy,
  output logic         job_done,
  output logic         job_err,
  output logic [1:0]   xex_mode,
  output logic         xex_in_rdy,
  output logic [127:0] xex_sector,
  output logic [127:0] xex_data_in,
  input  logic         xex_out_rdy,
  input  logic         xex_busy,
  input  logic [127:0] xex_data_out
);

  // Elaboration-time guard on the parameter ranges the counters can represent
  if (MAX_BLOCKS < 1 || MAX_BLOCKS > 63 || WD_LIMIT < 2 || WD_LIMIT > 256) begin : g_bad_params
    $error("xex_block_sequencer: MAX_BLOCKS or WD_LIMIT out of range");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t       state, state_nxt;
  logic         dir, err;
  logic [127:0] sector;
  logic [5:0]   nblocks, written, issued, received;
  logic [127:0] fifo_mem [2];
  logic         fifo_rd_ptr, fifo_wr_ptr;
  logic [1:0]   fifo_cnt;
  logic [127:0] hold, out_q;
  logic         out_vld;
  logic         start_acc, issue, capture, abort, finish, push;
  logic [5:0]   nb_clamped;

`ifdef XEX_SEQ_WATCHDOG_EN
  logic [7:0]   wd_cnt;
`endif

  assign nb_clamped = (cmd_nblocks > 6'(MAX_BLOCKS)) ? 6'(MAX_BLOCKS) : cmd_nblocks;
  assign push       = wr_valid && wr_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!n_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    issue     = 1'b0;
    capture   = 1'b0;
    abort     = 1'b0;
    finish    = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_start) begin
          start_acc = 1'b1;
          state_nxt = (nb_clamped == 6'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fifo_cnt != 2'd0 && !xex_busy && !out_vld && issued < nblocks) begin
          issue     = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (xex_out_rdy) begin
          capture   = 1'b1;
          state_nxt = ((received + 6'd1) == nblocks) ? S_DONE : S_ISSUE;
        end
`ifdef XEX_SEQ_WATCHDOG_EN
        else if (wd_cnt == 8'(WD_LIMIT - 1)) begin
          abort     = 1'b1;
          state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (!out_vld) begin
          finish    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Job context, counters, input FIFO, data hold and output register
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      dir         <= 1'b0;
      err         <= 1'b0;
      sector      <= '0;
      nblocks     <= '0;
      written     <= '0;
      issued      <= '0;
      received    <= '0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
      fifo_rd_ptr <= 1'b0;
      fifo_wr_ptr <= 1'b0;
      fifo_cnt    <= '0;
      hold        <= '0;
      out_q       <= '0;
      out_vld     <= 1'b0;
    end else begin
      if (start_acc) begin
        dir      <= cmd_dec;
        sector   <= cmd_sector;
        nblocks  <= nb_clamped;
        err      <= (nb_clamped == 6'd0);
        written  <= '0;
        issued   <= '0;
        received <= '0;
      end
      if (push) written <= written + 6'd1;
      if (issue) begin
        issued <= issued + 6'd1;
        hold   <= fifo_mem[fifo_rd_ptr];
      end
      if (capture) begin
        out_q    <= xex_data_out;
        out_vld  <= 1'b1;
        received <= received + 6'd1;
      end else if (out_vld && rd_ready) begin
        out_vld <= 1'b0;
      end
      if (abort) begin
        err     <= 1'b1;
        out_vld <= 1'b0;
      end
      // An aborted or freshly started job must not see stale blocks
      if (abort || start_acc) begin
        fifo_rd_ptr <= 1'b0;
        fifo_wr_ptr <= 1'b0;
        fifo_cnt    <= '0;
      end else begin
        if (push) begin
          fifo_mem[fifo_wr_ptr] <= wr_data;
          fifo_wr_ptr           <= ~fifo_wr_ptr;
        end
        if (issue) fifo_rd_ptr <= ~fifo_rd_ptr;
        case ({push, issue})
          2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
          2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
          default: fifo_cnt <= fifo_cnt;
        endcase
      end
    end
  end

`ifdef XEX_SEQ_WATCHDOG_EN
  // Watchdog: restarts at each block issue, counts cycles spent in WAIT
  always_ff @(posedge clk) begin
    if (!n_rst)                wd_cnt <= '0;
    else if (issue)            wd_cnt <= '0;
    else if (state == S_WAIT)  wd_cnt <= wd_cnt + 8'd1;
  end
`endif

  assign job_busy    = (state != S_IDLE);
  assign job_done    = finish;
  assign job_err     = finish && err;
  assign wr_ready    = job_busy && (fifo_cnt != 2'd2) && (written < nblocks);
  assign rd_valid    = out_vld;
  assign rd_data     = out_q;
  assign xex_mode    = (state == S_ISSUE || state == S_WAIT) ? {1'b1, dir} : 2'b00;
  assign xex_in_rdy  = issue;
  assign xex_sector  = sector;
  // FIFO head is presented during the issue strobe, the hold register keeps it stable afterwards
  assign xex_data_in = issue ? fifo_mem[fifo_rd_ptr] : hold;

endmodule

// File: tb/tb_xex_block_sequencer.sv
// Randomized scoreboard bench for xex_block_sequencer with a behavioural XEX engine model.
// Expected blocks/results/done flags are queued at job issue; a negedge monitor pops and compares.
// Watchdog scenario runs only when XEX_SEQ_WATCHDOG_EN is defined.
module tb_xex_block_sequencer;

  localparam int          MAXB = 32;
  localparam logic [127:0] ALL1 = {128{1'b1}};

  logic         clk = 1'b0;
  logic         n_rst, cmd_start, cmd_dec;
  logic [127:0] cmd_sector;
  logic [5:0]   cmd_nblocks;
  logic         wr_valid, wr_ready;
  logic [127:0] wr_data;
  logic         rd_valid, rd_ready;
  logic [127:0] rd_data;
  logic         job_busy, job_done, job_err;
  logic [1:0]   xex_mode;
  logic         xex_in_rdy;
  logic [127:0] xex_sector, xex_data_in;
  logic         xex_out_rdy, xex_busy;
  logic [127:0] xex_data_out;

  xex_block_sequencer dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_start(cmd_start), .cmd_dec(cmd_dec), .cmd_sector(cmd_sector), .cmd_nblocks(cmd_nblocks),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .job_busy(job_busy), .job_done(job_done), .job_err(job_err),
    .xex_mode(xex_mode), .xex_in_rdy(xex_in_rdy), .xex_sector(xex_sector), .xex_data_in(xex_data_in),
    .xex_out_rdy(xex_out_rdy), .xex_busy(xex_busy), .xex_data_out(xex_data_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [127:0] exp_out_q[$];
  logic [127:0] exp_in_q[$];
  bit           exp_done_q[$];
  logic [1:0]   exp_mode;
  logic [127:0] exp_sector;
  logic [127:0] blk [64];
  int           n_inrdy = 0;
  int           wr_accepted = 0;
  bit           wr_abort = 0;
  bit           hold_arm = 0;
  int           hold_cnt = 0;
  int           eng_lat = 4;
  bit           eng_hang = 0;
  int           eng_left = 0;
  bit           eng_saw_issue = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Engine model: returns data_in ^ all-ones eng_lat cycles after an issue, busy meanwhile
  always @(negedge clk) eng_saw_issue = xex_in_rdy;
  initial begin
    xex_out_rdy = 1'b0; xex_busy = 1'b0; xex_data_out = '0;
    forever begin
      @(posedge clk); #1;
      xex_out_rdy = 1'b0;
      if (eng_left > 0) begin
        eng_left--;
        if (eng_left == 0) begin
          xex_data_out = xex_data_in ^ ALL1;
          xex_out_rdy  = 1'b1;
          xex_busy     = 1'b0;
        end
      end
      if (eng_saw_issue) begin
        if (eng_hang) eng_left = 0;
        else begin eng_left = eng_lat; xex_busy = 1'b1; end
      end
    end
  end

  // Monitor: drives rd_ready, checks results, issue strobes and completion flags
  always @(negedge clk) begin
    if (hold_cnt > 0) begin rd_ready = 1'b0; hold_cnt--; end
    else if (hold_arm && rd_valid) begin hold_arm = 0; hold_cnt = 19; rd_ready = 1'b0; end
    else rd_ready = ($urandom_range(0, 3) != 0);
    if (rd_valid && rd_ready) begin
      if (exp_out_q.size() == 0) chk("rd_extra", rd_valid, 1'b0);
      else chk("rd_data", rd_data, exp_out_q.pop_front());
    end
    if (xex_in_rdy) begin
      n_inrdy++;
      chk("inrdy_engine_idle", xex_busy, 1'b0);
      chk("inrdy_rd_empty", rd_valid, 1'b0);
      chk("inrdy_mode", xex_mode, exp_mode);
      chk("inrdy_sector", xex_sector, exp_sector);
      if (exp_in_q.size() == 0) chk("inrdy_extra", xex_in_rdy, 1'b0);
      else chk("inrdy_data", xex_data_in, exp_in_q.pop_front());
    end
    if (job_done) begin
      if (exp_done_q.size() == 0) chk("done_extra", job_done, 1'b0);
      else chk("done_err", job_err, exp_done_q.pop_front());
    end
  end

  task automatic host_write(input int nw, input int eff);
    int  t;
    bit  acc;
    int  acc_n;
    acc_n = 0;
    for (int i = 0; i < nw && !wr_abort; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      wr_valid = 1'b1; wr_data = blk[i];
      acc = 0; t = 0;
      while (!acc && t < ((i < eff) ? 400 : 20) && !wr_abort) begin
        if (wr_ready) begin @(posedge clk); acc = 1; end
        @(negedge clk); t++;
      end
      wr_valid = 1'b0;
      if (acc) acc_n++;
    end
    wr_accepted = acc_n;
  endtask

  task automatic start_job(input bit dir, input logic [127:0] sec, input int nb, input int nw,
                           input bit out_exp, input bit err_exp, input bit hold, output int eff);
    eff = (nb > MAXB) ? MAXB : nb;
    for (int i = 0; i < nw; i++) blk[i] = rnd128();
    for (int i = 0; i < eff; i++) begin
      exp_in_q.push_back(blk[i]);
      if (out_exp) exp_out_q.push_back(blk[i] ^ ALL1);
    end
    exp_done_q.push_back(err_exp);
    exp_mode = {1'b1, dir}; exp_sector = sec; n_inrdy = 0; hold_arm = hold;
    cmd_dec = dir; cmd_sector = sec; cmd_nblocks = 6'(nb); cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0; cmd_dec = 1'($urandom); cmd_sector = rnd128(); cmd_nblocks = 6'($urandom);
    chk("busy_after_start", job_busy, 1'b1);
    if (eff == 0) begin
      chk("empty_done", job_done, 1'b1);
      chk("empty_err", job_err, 1'b1);
      chk("empty_mode", xex_mode, 2'b00);
    end else begin
      chk("mode_after_start", xex_mode, exp_mode);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!job_done && t < 5000) begin @(negedge clk); t++; end
    chk("done_seen", job_done, 1'b1);
    @(negedge clk);
    chk("busy_fall", job_busy, 1'b0);
    chk("done_pulse", job_done, 1'b0);
  endtask

  task automatic run_job(input bit dir, input logic [127:0] sec, input int nb, input int nw, input bit hold);
    int eff;
    start_job(dir, sec, nb, nw, 1'b1, (nb == 0), hold, eff);
    fork
      host_write(nw, eff);
      wait_done();
    join
    chk("writes_accepted", wr_accepted, eff);
    chk("inrdy_count", n_inrdy, eff);
    chk("results_drained", exp_out_q.size(), 0);
    chk("mode_idle", xex_mode, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not reach its end");
    $fatal(1, "time limit");
  end

  initial begin
    int eff, c, t, nb;
    bit saw, saw_late;
    n_rst = 1'b0; cmd_start = 1'b0; cmd_dec = 1'b0; cmd_sector = '0; cmd_nblocks = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {wr_ready, rd_valid, job_busy, job_done, job_err, xex_mode, xex_in_rdy}, '0);
    chk("rst_rd_data", rd_data, '0);
    n_rst = 1'b1;
    @(negedge clk);

    eng_lat = 4;
    run_job(1'b0, 128'h1, 3, 3, 1'b0);            // encrypt, 3 blocks
    run_job(1'b1, rnd128(), 3, 3, 1'b1);          // decrypt, reader stalls 20 cycles
    run_job(1'b0, rnd128(), 0, 0, 1'b0);          // empty job
    run_job(1'b0, rnd128(), 2, 5, 1'b0);          // host over-writes
    run_job(1'b1, rnd128(), 63, 33, 1'b0);        // clamped to MAX_BLOCKS
    for (int j = 0; j < 6; j++) begin
      eng_lat = $urandom_range(1, 6);
      nb = $urandom_range(1, 6);
      run_job(1'($urandom), rnd128(), nb, nb + $urandom_range(0, 1), 1'b0);
    end

    // Reset while block 2 of 4 is in flight
    eng_lat = 12;
    start_job(1'b0, rnd128(), 4, 4, 1'b1, 1'b0, 1'b0, eff);
    fork
      host_write(4, 4);
      begin
        c = 0; t = 0;
        while (c < 2 && t < 500) begin @(negedge clk); t++; if (xex_in_rdy) c++; end
        chk("rst_reach_block2", c, 2);
        repeat (3) @(negedge clk);
        n_rst = 1'b0; wr_abort = 1;
        @(negedge clk);
        n_rst = 1'b1;
        chk("midrst_ctrl", {wr_ready, rd_valid, job_busy, job_done, job_err, xex_mode, xex_in_rdy}, '0);
        chk("midrst_rd_data", rd_data, '0);
        chk("midrst_sector", xex_sector, '0);
        chk("midrst_data_in", xex_data_in, '0);
        exp_out_q.delete(); exp_in_q.delete(); exp_done_q.delete();
      end
    join
    saw = 0; saw_late = 0;
    repeat (16) begin
      @(negedge clk);
      saw = saw | rd_valid | job_done | job_busy;
      saw_late = saw_late | xex_out_rdy;
    end
    chk("late_result_ignored", saw, 1'b0);
    chk("late_result_arrived", saw_late, 1'b1);
    wr_abort = 0; eng_lat = 4;
    run_job(1'b1, rnd128(), 4, 4, 1'b0);

`ifdef XEX_SEQ_WATCHDOG_EN
    eng_hang = 1;
    start_job(1'b0, rnd128(), 1, 1, 1'b0, 1'b1, 1'b0, eff);
    fork
      host_write(1, 1);
      begin
        t = 0;
        while (!xex_in_rdy && t < 200) begin @(negedge clk); t++; end
        chk("wd_issued", xex_in_rdy, 1'b1);
        t = 0;
        while (!job_done && t < 400) begin @(negedge clk); t++; end
        chk("wd_cycles", t, 256);
        chk("wd_err", job_err, 1'b1);
        chk("wd_mode", xex_mode, 2'b00);
        chk("wd_rd_valid", rd_valid, 1'b0);
        @(negedge clk);
        chk("wd_idle", job_busy, 1'b0);
      end
    join
    eng_hang = 0;
`endif

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
